// File: rtl/mult_ctrl.sv
// mult_ctrl: control and datapath-feed stage for a shift-add multiplier.
// It drives the Load/Ad/Sh strobes and the next-value bus of an external
// (2W+1)-bit accumulator, and it captures the 2W-bit product.
// Optional build macro MULT_ADDSHIFT_EN: fuses add and shift into one BIT
// cycle, which gives a fixed latency.
//
// Handshake: a request is accepted on any rising edge where Start=1 and
// the FSM is IDLE. Busy is high from the next cycle through DONE. While
// Busy is high, Start is ignored. Done is a one-cycle pulse. Product is
// valid in the Done cycle and holds until the next completion.
module mult_ctrl #(
   parameter int W = 16
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic           Start,
   input  logic [W-1:0]   Multiplicand,
   input  logic [W-1:0]   Multiplier,
   input  logic [2*W:0]   Acc,
   output logic [2*W:0]   AccIn,
   output logic           Load,
   output logic           Ad,
   output logic           Sh,
   output logic           Busy,
   output logic           Done,
   output logic [2*W-1:0] Product,
   output logic [2:0]     state_dbg
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

`ifdef MULT_ADDSHIFT_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_BIT   = 3'd2,
      S_DONE  = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_BIT   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;
`endif

   state_t          state, state_nx;
   logic [W-1:0]    mcand_r, mplier_r;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            accept;

   // The accumulator carry bit is rebuilt from the adder every cycle, so
   // its feedback value is never needed here.
   logic            unused_acc_msb;
   assign unused_acc_msb = Acc[2*W];

   assign last      = (cnt == CNT_LAST);
   assign accept    = (state == S_IDLE) && Start;
   assign state_dbg = state;

   // Next-value bus: adder on the upper half, multiplier fed into the lower half during LOAD.
   always_comb begin
      AccIn[2*W:W] = {1'b0, Acc[2*W-1:W]} + {1'b0, mcand_r};
      AccIn[W-1:0] = (state == S_LOAD) ? mplier_r : Acc[W-1:0];
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (Start) state_nx = S_LOAD;
         S_LOAD:  state_nx = S_BIT;
`ifdef MULT_ADDSHIFT_EN
         S_BIT:   state_nx = last ? S_DONE : S_BIT;
`else
         S_BIT: begin
            if (Acc[0])    state_nx = S_SHIFT;
            else if (last) state_nx = S_DONE;
         end
         S_SHIFT: state_nx = last ? S_DONE : S_BIT;
`endif
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output strobes, decoded from the state and the multiplier bit now in Acc[0].
   always_comb begin
      Load = 1'b0;
      Ad   = 1'b0;
      Sh   = 1'b0;
      Busy = (state != S_IDLE);
      case (state)
         S_LOAD: Load = 1'b1;
         S_BIT: begin
`ifdef MULT_ADDSHIFT_EN
            Ad = Acc[0];
            Sh = 1'b1;
`else
            if (Acc[0]) Ad = 1'b1;
            else        Sh = 1'b1;
`endif
         end
`ifndef MULT_ADDSHIFT_EN
         S_SHIFT: Sh = 1'b1;
`endif
         default: ;
      endcase
   end

   // Operand latches and bit counter. The counter advances once per shift.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         cnt      <= '0;
      end else if (accept) begin
         mcand_r  <= Multiplicand;
         mplier_r <= Multiplier;
         cnt      <= '0;
      end else if (Sh) begin
         cnt      <= cnt + CW'(1);
      end
   end

   // Result capture and completion pulse.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Product <= '0;
         Done    <= 1'b0;
      end else begin
         Done <= (state == S_DONE);
         if (state == S_DONE) Product <= Acc[2*W-1:0];
      end
   end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed testbench for mult_ctrl. The bench models the 33-bit accumulator
// register that closes the loop: Load clears the upper half and takes the
// multiplier, Ad takes the adder half, Sh shifts right, and Ad+Sh together
// add and then shift in the same edge.
module tb_mult_ctrl;
   localparam int W = 16;

   logic           Clk = 1'b0;
   logic           Rst;
   logic           Start;
   logic [W-1:0]   Multiplicand, Multiplier;
   logic [2*W:0]   Acc;
   logic [2*W:0]   AccIn;
   logic           Load, Ad, Sh, Busy, Done;
   logic [2*W-1:0] Product;
   logic [2:0]     state_dbg;

   int n_cmp  = 0;
   int n_fail = 0;
   int ad_total   = 0;
   int both_total = 0;

   // Clock and watchdog.
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end, required finish");
      $fatal(1);
   end

   mult_ctrl #(.W(W)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Start        (Start),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Acc          (Acc),
      .AccIn        (AccIn),
      .Load         (Load),
      .Ad           (Ad),
      .Sh           (Sh),
      .Busy         (Busy),
      .Done         (Done),
      .Product      (Product),
      .state_dbg    (state_dbg)
   );

   // Accumulator register model.
   always @(posedge Clk) begin
      if (Rst)              Acc <= '0;
      else if (Load)        Acc <= {17'b0, AccIn[15:0]};
      else if (Ad && Sh)    Acc <= {1'b0, AccIn[32:16], Acc[15:1]};
      else if (Ad)          Acc <= {AccIn[32:16], Acc[15:0]};
      else if (Sh)          Acc <= {1'b0, Acc[32:1]};
   end

   // Strobe activity counters.
   always @(posedge Clk) begin
      if (Ad)       ad_total   <= ad_total + 1;
      if (Ad && Sh) both_total <= both_total + 1;
   end

   function automatic int lat(input int p);
`ifdef MULT_ADDSHIFT_EN
      return 3 + W;
`else
      return 3 + W + p;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One pulsed-Start multiply with hand-computed product, latency and add count.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input int exp_cyc, input int exp_ads);
      int cyc;
      int ad0;
      ad0 = ad_total;
      Multiplicand = a;
      Multiplier   = b;
      Start        = 1'b1;
      @(negedge Clk);
      cyc = 1;
      Start        = 1'b0;
      Multiplicand = 16'($urandom_range(0, 65535));
      Multiplier   = 16'($urandom_range(0, 65535));
      check({tag, "_load"}, 64'(Load), 64'd1);
      check({tag, "_busy"}, 64'(Busy), 64'd1);
      while (!Done && cyc < 200) begin
         @(negedge Clk);
         cyc++;
      end
      check({tag, "_cycle"},   64'(cyc), 64'(exp_cyc));
      check({tag, "_product"}, 64'(Product), 64'(exp_p));
      check({tag, "_idle"},    64'(Busy), 64'd0);
      check({tag, "_adds"},    64'(ad_total - ad0), 64'(exp_ads));
      @(negedge Clk);
      check({tag, "_donefall"}, 64'(Done), 64'd0);
   endtask

   // Directed sequence.
   initial begin
      int cyc;
      int cyc2;
      bit done_seen;

      Rst = 1'b1;
      Start = 1'b0;
      Multiplicand = '0;
      Multiplier = '0;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      check("rst_state",   64'(state_dbg), 64'd0);
      check("rst_product", 64'(Product), 64'd0);
      check("rst_done",    64'(Done), 64'd0);
      check("rst_busy",    64'(Busy), 64'd0);
      check("rst_strobes", 64'({Load, Ad, Sh}), 64'd0);
      @(negedge Clk);

      run_op("m3x5",    16'd3,      16'd5,      32'h0000000F, lat(2),  2);
      run_op("mffxff",  16'hFFFF,   16'hFFFF,   32'hFFFE0001, lat(16), 16);
      run_op("m1234x0", 16'h1234,   16'h0000,   32'h00000000, lat(0),  0);
      run_op("m1xffff", 16'h0001,   16'hFFFF,   32'h0000FFFF, lat(16), 16);

      // 7 x 9 with Start re-pulsed on new operands at cycles 5 and 10.
      Multiplicand = 16'd7;
      Multiplier   = 16'd9;
      Start        = 1'b1;
      @(negedge Clk);
      cyc = 1;
      Start = 1'b0;
      while (!Done && cyc < 200) begin
         @(negedge Clk);
         cyc++;
         if (cyc == 5 || cyc == 10) begin
            Start        = 1'b1;
            Multiplicand = 16'($urandom_range(1, 65535));
            Multiplier   = 16'($urandom_range(1, 65535));
         end else begin
            Start = 1'b0;
         end
      end
      check("repulse_cycle",   64'(cyc), 64'(lat(2)));
      check("repulse_product", 64'(Product), 64'd63);
      Start = 1'b0;
      @(negedge Clk);

      // Start held high: 3 x 5, then 0x00FF x 0x0101 accepted in the Done cycle.
      Multiplicand = 16'd3;
      Multiplier   = 16'd5;
      Start        = 1'b1;
      @(negedge Clk);
      cyc = 1;
      Multiplicand = 16'h00FF;
      Multiplier   = 16'h0101;
      while (!Done && cyc < 200) begin
         @(negedge Clk);
         cyc++;
      end
      check("held1_cycle",   64'(cyc), 64'(lat(2)));
      check("held1_product", 64'(Product), 64'h0F);
      @(negedge Clk);
      cyc2 = 1;
      Start = 1'b0;
      check("held2_load",    64'(Load), 64'd1);
      repeat (9) @(negedge Clk);
      cyc2 += 9;
      check("held2_hold",    64'(Product), 64'h0F);
      while (!Done && cyc2 < 200) begin
         @(negedge Clk);
         cyc2++;
      end
      check("held2_cycle",   64'(cyc2), 64'(lat(2)));
      check("held2_product", 64'(Product), 64'h0000FFFF);
      @(negedge Clk);

      // Reset in cycle 8 of a multiply aborts it without a Done pulse.
      Multiplicand = 16'hFFFF;
      Multiplier   = 16'hFFFF;
      Start        = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (7) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check("abort_state",   64'(state_dbg), 64'd0);
      check("abort_busy",    64'(Busy), 64'd0);
      check("abort_product", 64'(Product), 64'd0);
      check("abort_done",    64'(Done), 64'd0);
      check("abort_strobes", 64'({Load, Ad, Sh}), 64'd0);
      done_seen = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         if (Done) done_seen = 1'b1;
      end
      check("abort_nodone", 64'(done_seen), 64'd0);

      run_op("m2x2", 16'd2, 16'd2, 32'h00000004, lat(1), 1);

`ifdef MULT_ADDSHIFT_EN
      check("ad_sh_together", 64'(both_total != 0), 64'd1);
`else
      check("ad_sh_exclusive", 64'(both_total), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
